// File: rtl/irq_controller_pkg.sv
// Shared definitions for the platform interrupt controller:
// register byte offsets, gateway mode encoding and the source-ID width helper.
// No ports; imported by irq_gateway and irq_controller.
package riscv_irq_pkg;

  // Register byte offsets (8-byte aligned)
  localparam logic [15:0] IRQ_PENDING_OFF = 16'h0000;
  localparam logic [15:0] IRQ_ENABLE_OFF  = 16'h0008;
  localparam logic [15:0] IRQ_MODE_OFF    = 16'h0010;
  localparam logic [15:0] IRQ_THRESH_OFF  = 16'h0018;
  localparam logic [15:0] IRQ_CLAIM_OFF   = 16'h0020;
  localparam logic [15:0] IRQ_PRIO_BASE   = 16'h0040;

  typedef enum logic {
    IRQ_LEVEL = 1'b0,
    IRQ_EDGE  = 1'b1
  } irq_mode_e;

  // Width needed to carry IDs 0..num_src
  function automatic int unsigned irq_id_w(input int unsigned num_src);
    return $clog2(num_src + 1);
  endfunction

endpackage

// File: rtl/irq_controller_if.sv
// Memory-mapped register bus between the core and the interrupt controller.
// Signals: bus_address (byte offset), bus_write_data, bus_write_enable,
// bus_read_enable (single-cycle strobes), bus_read_data (valid one cycle
// after bus_read_enable). master = core side, slave = controller side.
interface irq_controller_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 64
);
  logic [ADDR_W-1:0] bus_address;
  logic [DATA_W-1:0] bus_write_data;
  logic              bus_write_enable;
  logic              bus_read_enable;
  logic [DATA_W-1:0] bus_read_data;

  modport master (
    output bus_address, bus_write_data, bus_write_enable, bus_read_enable,
    input  bus_read_data
  );

  modport slave (
    input  bus_address, bus_write_data, bus_write_enable, bus_read_enable,
    output bus_read_data
  );
endinterface

// File: rtl/irq_gateway.sv
// Per-source interrupt gateway: turns a raw (clk-synchronous) line into
// pending / in-service state in edge or level mode.
// Ports: clk, reset (async active-high), src (source line), mode (edge/level),
// claim (core claimed this ID), complete (core finished this ID),
// pending, in_service (registered state).
module irq_gateway
  import riscv_irq_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  input  logic      src,
  input  irq_mode_e mode,
  input  logic      claim,
  input  logic      complete,
  output logic      pending,
  output logic      in_service
);

  logic prev;
  logic set;

  // Edge mode: a rising edge sets pending even over a claim in the same cycle.
  // Level mode: a claimed source must not re-pend on the claiming edge.
  always_comb begin
    set = 1'b0;
    if (mode == IRQ_EDGE) set = src & ~prev;
    else                  set = src & ~in_service & ~claim;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev       <= 1'b0;
      pending    <= 1'b0;
      in_service <= 1'b0;
    end else begin
      prev       <= src;
      pending    <= set | (pending & ~claim);
      in_service <= claim | (in_service & ~complete);
    end
  end

endmodule

// File: rtl/irq_controller.sv
// Platform interrupt controller: NUM_SRC prioritised sources, one registered
// ext_irq line to the core, claim/complete through memory-mapped registers.
// Ports: clk, reset (async active-high), irq_src (bit i-1 = ID i),
// bus (irq_controller_if.slave register bus), ext_irq (registered request),
// best_id (registered winning ID, 0 = none).
// Build option: define IRQ_SYNC_EN to put a 2-flop synchroniser on every
// irq_src bit ahead of its gateway.
module irq_controller
  import riscv_irq_pkg::*;
#(
  parameter  int unsigned NUM_SRC = 8,
  parameter  int unsigned PRIO_W  = 3,
  parameter  int unsigned ADDR_W  = 16,
  parameter  int unsigned DATA_W  = 64,
  localparam int unsigned ID_W    = irq_id_w(NUM_SRC)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_SRC-1:0]  irq_src,
  irq_controller_if.slave     bus,
  output logic                ext_irq,
  output logic [ID_W-1:0]     best_id
);

  logic [NUM_SRC-1:0] src_s;
  logic [NUM_SRC:1]   enable;
  logic [NUM_SRC:1]   mode;
  logic [NUM_SRC:1]   pending;
  logic [NUM_SRC:1]   in_service;
  logic [NUM_SRC:1]   claim_vec;
  logic [NUM_SRC:1]   complete_vec;
  logic [NUM_SRC:1]   prio_sel;
  logic [PRIO_W-1:0]  threshold;
  logic [PRIO_W-1:0]  prio [1:NUM_SRC];
  logic [ID_W-1:0]    win_id;
  logic [PRIO_W-1:0]  win_prio;
  logic [DATA_W-1:0]  rdata_c;
  logic               claim_hit;

  // Optional input synchroniser
`ifdef IRQ_SYNC_EN
  logic [NUM_SRC-1:0] sync_q1;
  logic [NUM_SRC-1:0] sync_q2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= irq_src;
      sync_q2 <= sync_q1;
    end
  end

  assign src_s = sync_q2;
`else
  assign src_s = irq_src;
`endif

  assign claim_hit = (bus.bus_address == ADDR_W'(IRQ_CLAIM_OFF));

  // Address decode for PRIORITY[i] and claim/complete strobes per ID
  always_comb begin
    for (int i = 1; i <= NUM_SRC; i++) begin
      prio_sel[i]     = (bus.bus_address == ADDR_W'(int'(IRQ_PRIO_BASE) + 8 * i));
      claim_vec[i]    = bus.bus_read_enable & claim_hit & (best_id == ID_W'(i));
      // Full-width compare rejects ID 0 and IDs above NUM_SRC
      complete_vec[i] = bus.bus_write_enable & claim_hit &
                        (bus.bus_write_data == DATA_W'(i)) & in_service[i];
    end
  end

  // Gateways, one per source ID
  for (genvar g = 1; g <= NUM_SRC; g++) begin : g_gw
    irq_gateway u_gw (
      .clk        (clk),
      .reset      (reset),
      .src        (src_s[g-1]),
      .mode       (irq_mode_e'(mode[g])),
      .claim      (claim_vec[g]),
      .complete   (complete_vec[g]),
      .pending    (pending[g]),
      .in_service (in_service[g])
    );
  end

  // Configuration registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      enable    <= '0;
      mode      <= '0;
      threshold <= '0;
      for (int i = 1; i <= NUM_SRC; i++) prio[i] <= '0;
    end else if (bus.bus_write_enable) begin
      if (bus.bus_address == ADDR_W'(IRQ_ENABLE_OFF)) enable    <= bus.bus_write_data[NUM_SRC:1];
      if (bus.bus_address == ADDR_W'(IRQ_MODE_OFF))   mode      <= bus.bus_write_data[NUM_SRC:1];
      if (bus.bus_address == ADDR_W'(IRQ_THRESH_OFF)) threshold <= bus.bus_write_data[PRIO_W-1:0];
      for (int i = 1; i <= NUM_SRC; i++) begin
        if (prio_sel[i]) prio[i] <= bus.bus_write_data[PRIO_W-1:0];
      end
    end
  end

  // Arbiter: the running best starts at the threshold so "priority > threshold"
  // and "beats current winner" share one strict compare; ascending scan with
  // strict > leaves ties to the lowest ID.
  always_comb begin
    win_id   = '0;
    win_prio = threshold;
    for (int i = 1; i <= NUM_SRC; i++) begin
      if (pending[i] && enable[i] && (prio[i] > win_prio)) begin
        win_id   = ID_W'(i);
        win_prio = prio[i];
      end
    end
  end

  // Read mux over pre-write register state
  always_comb begin
    rdata_c = '0;
    if (bus.bus_address == ADDR_W'(IRQ_PENDING_OFF)) rdata_c = DATA_W'({pending, 1'b0});
    if (bus.bus_address == ADDR_W'(IRQ_ENABLE_OFF))  rdata_c = DATA_W'({enable, 1'b0});
    if (bus.bus_address == ADDR_W'(IRQ_MODE_OFF))    rdata_c = DATA_W'({mode, 1'b0});
    if (bus.bus_address == ADDR_W'(IRQ_THRESH_OFF))  rdata_c = DATA_W'(threshold);
    if (claim_hit)                                   rdata_c = DATA_W'(best_id);
    for (int i = 1; i <= NUM_SRC; i++) begin
      if (prio_sel[i]) rdata_c = DATA_W'(prio[i]);
    end
  end

  // Output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      best_id           <= '0;
      ext_irq           <= 1'b0;
      bus.bus_read_data <= '0;
    end else begin
      best_id <= win_id;
      ext_irq <= (win_id != '0);
      if (bus.bus_read_enable) bus.bus_read_data <= rdata_c;
    end
  end

endmodule

// File: tb/tb_irq_controller.sv
// Directed self-checking bench for irq_controller with a behavioural
// reference model compared every cycle.
module tb_irq_controller;
  import riscv_irq_pkg::*;

`ifdef IRQ_SYNC_EN
  localparam int SL = 2;
`else
  localparam int SL = 0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  irq_src;
  logic        ext_irq;
  logic [3:0]  best_id;
  logic [63:0] d;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  irq_controller_if #(.ADDR_W(16), .DATA_W(64)) bus ();

  irq_controller #(.NUM_SRC(8), .PRIO_W(3), .ADDR_W(16), .DATA_W(64)) dut (
    .clk     (clk),
    .reset   (reset),
    .irq_src (irq_src),
    .bus     (bus),
    .ext_irq (ext_irq),
    .best_id (best_id)
  );

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [8:0]  m_pend, m_isv, m_en, m_mode, m_prev;
  logic [2:0]  m_thr;
  logic [2:0]  m_prio [1:8];
  int          m_best;
  logic [63:0] m_rdata;
  bit          m_rvalid;
  logic [7:0]  sq1, sq2;

  // Highest priority first; within a priority the first (lowest) ID wins
  function automatic int winner();
    for (int p = 7; p >= 1; p--) begin
      if (p > int'(m_thr)) begin
        for (int id = 1; id <= 8; id++)
          if (m_pend[id] && m_en[id] && int'(m_prio[id]) == p) return id;
      end
    end
    return 0;
  endfunction

  function automatic logic [63:0] reg_read(input logic [15:0] a);
    if (a == 16'h00) return 64'(m_pend);
    if (a == 16'h08) return 64'(m_en);
    if (a == 16'h10) return 64'(m_mode);
    if (a == 16'h18) return 64'(m_thr);
    if (a == 16'h20) return 64'(m_best);
    if (a >= 16'h48 && a <= 16'h80 && a[2:0] == 3'b000)
      return 64'(m_prio[int'((a - 16'h40) >> 3)]);
    return 64'd0;
  endfunction

  always @(posedge clk or posedge reset) begin : model
    logic [8:0]  s, np, ni;
    logic [15:0] a;
    logic [63:0] wd;
    int          cid, nb;
    if (reset) begin
      m_pend <= '0; m_isv <= '0; m_en <= '0; m_mode <= '0; m_prev <= '0;
      m_thr <= '0; m_best <= 0; m_rdata <= '0; m_rvalid <= 1'b0;
      sq1 <= '0; sq2 <= '0;
      for (int i = 1; i <= 8; i++) m_prio[i] <= '0;
    end else begin
      a  = bus.bus_address;
      wd = bus.bus_write_data;
`ifdef IRQ_SYNC_EN
      s = {sq2, 1'b0};
`else
      s = {irq_src, 1'b0};
`endif
      nb  = winner();
      cid = (bus.bus_read_enable && a == 16'h20) ? m_best : 0;
      m_rvalid <= bus.bus_read_enable;
      if (bus.bus_read_enable) m_rdata <= reg_read(a);
      np = '0;
      ni = m_isv;
      for (int id = 1; id <= 8; id++) begin
        if (m_mode[id]) np[id] = s[id] && !m_prev[id];
        else            np[id] = s[id] && !m_isv[id] && (id != cid);
        if (m_pend[id] && id != cid) np[id] = 1'b1;
      end
      if (bus.bus_write_enable && a == 16'h20 && wd >= 64'd1 && wd <= 64'd8)
        ni[int'(wd[3:0])] = 1'b0;
      if (cid != 0) ni[cid] = 1'b1;
      if (bus.bus_write_enable) begin
        if (a == 16'h08) m_en   <= {wd[8:1], 1'b0};
        if (a == 16'h10) m_mode <= {wd[8:1], 1'b0};
        if (a == 16'h18) m_thr  <= wd[2:0];
        if (a >= 16'h48 && a <= 16'h80 && a[2:0] == 3'b000)
          m_prio[int'((a - 16'h40) >> 3)] <= wd[2:0];
      end
      m_pend <= np;
      m_isv  <= ni;
      m_prev <= s;
      m_best <= nb;
      sq1    <= irq_src;
      sq2    <= sq1;
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (reset) begin
      chk("rst_best_id", 64'(best_id), 64'd0);
      chk("rst_ext_irq", 64'(ext_irq), 64'd0);
      chk("rst_read_data", bus.bus_read_data, 64'd0);
    end else begin
      chk("best_id", 64'(best_id), 64'(m_best));
      chk("ext_irq", 64'(ext_irq), 64'(m_best != 0));
      if (m_rvalid) chk("read_data", bus.bus_read_data, m_rdata);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [15:0] a, input logic [63:0] v);
    bus.bus_address      = a;
    bus.bus_write_data   = v;
    bus.bus_write_enable = 1'b1;
    @(negedge clk);
    bus.bus_write_enable = 1'b0;
  endtask

  task automatic rd(input logic [15:0] a, output logic [63:0] v);
    bus.bus_address     = a;
    bus.bus_read_enable = 1'b1;
    @(negedge clk);
    bus.bus_read_enable = 1'b0;
    v = bus.bus_read_data;
  endtask

  task automatic do_reset();
    #2;
    reset = 1'b1;
    irq_src = '0;
    bus.bus_write_enable = 1'b0;
    bus.bus_read_enable  = 1'b0;
    idle(2);
    reset = 1'b0;
    idle(1);
  endtask

  task automatic pulse0();
    irq_src[0] = 1'b1;
    idle(1);
    irq_src[0] = 1'b0;
    idle(1);
  endtask

  initial begin
    reset = 1'b1;
    irq_src = '0;
    bus.bus_address = '0;
    bus.bus_write_data = '0;
    bus.bus_write_enable = 1'b0;
    bus.bus_read_enable = 1'b0;
    idle(2);
    reset = 1'b0;
    idle(1);

    // Reset values, unmapped and read-only accesses
    rd(16'h08, d);  chk("reset_enable", d, 64'd0);
    rd(16'h40, d);  chk("unmapped_0x40", d, 64'd0);
    wr(16'h00, 64'hFFFF);
    rd(16'h00, d);  chk("pending_ro", d, 64'd0);

    // 1: level source ID 2, claim / complete
    wr(16'h08, 64'h04); wr(16'h50, 64'd3); wr(16'h18, 64'd0); wr(16'h10, 64'd0);
    irq_src[1] = 1'b1;
    idle(1 + SL);   chk("t1_ext_early", 64'(ext_irq), 64'd0);
    idle(1);        chk("t1_ext", 64'(ext_irq), 64'd1);
    rd(16'h20, d);  chk("t1_claim", d, 64'd2);
    rd(16'h00, d);  chk("t1_pend_after_claim", d, 64'd0);
    idle(3);
    rd(16'h00, d);  chk("t1_no_repend", d, 64'd0);
    wr(16'h20, 64'd2);
    idle(1);
    rd(16'h00, d);  chk("t1_repend", d, 64'h04);

    // Simultaneous read and write of ENABLE: read sees the old value
    bus.bus_address = 16'h08;
    bus.bus_write_data = 64'h20;
    bus.bus_write_enable = 1'b1;
    bus.bus_read_enable = 1'b1;
    @(negedge clk);
    bus.bus_write_enable = 1'b0;
    bus.bus_read_enable = 1'b0;
    chk("rw_old_value", bus.bus_read_data, 64'h04);
    rd(16'h08, d);  chk("rw_new_value", d, 64'h20);

    // 2: priority and tie-break
    do_reset();
    wr(16'h08, 64'h28); wr(16'h58, 64'd2); wr(16'h68, 64'd6);
    irq_src = 8'h14;
    idle(3 + SL);   chk("t2_high_prio", 64'(best_id), 64'd5);
    wr(16'h68, 64'd2);
    chk("t2_cfg_not_yet", 64'(best_id), 64'd5);
    idle(1);        chk("t2_tie_low_id", 64'(best_id), 64'd3);

    // 3: threshold
    do_reset();
    wr(16'h08, 64'h08); wr(16'h58, 64'd4); wr(16'h18, 64'd4);
    irq_src = 8'h04;
    idle(3 + SL);   chk("t3_masked", 64'(ext_irq), 64'd0);
    rd(16'h00, d);  chk("t3_pending", d, 64'h08);
    wr(16'h18, 64'd3);
    chk("t3_thr_not_yet", 64'(ext_irq), 64'd0);
    idle(1);        chk("t3_unmasked", 64'(ext_irq), 64'd1);
    chk("t3_best", 64'(best_id), 64'd3);

    // 4: edge mode ID 1, one-deep latch while in service
    do_reset();
    wr(16'h08, 64'h02); wr(16'h10, 64'h02); wr(16'h48, 64'd1);
    pulse0();
    idle(1 + SL);   chk("t4_best", 64'(best_id), 64'd1);
    rd(16'h20, d);  chk("t4_claim1", d, 64'd1);
    pulse0();
    idle(1 + SL);
    rd(16'h00, d);  chk("t4_pend_in_service", d, 64'h02);
    pulse0();
    idle(1 + SL);
    rd(16'h20, d);  chk("t4_claim2", d, 64'd1);
    wr(16'h20, 64'd1);
    idle(2);
    rd(16'h00, d);  chk("t4_third_lost", d, 64'd0);

    // 5: claim coinciding with a fresh edge, then empty claim
    pulse0();
    idle(1 + SL);
    irq_src[0] = 1'b1;
    idle(SL);
    rd(16'h20, d);  chk("t5_claim_edge", d, 64'd1);
    irq_src[0] = 1'b0;
    idle(SL);
    rd(16'h00, d);  chk("t5_pend_kept", d, 64'h02);
    rd(16'h20, d);  chk("t5_claim_again", d, 64'd1);
    wr(16'h20, 64'd1);
    idle(2);
    rd(16'h20, d);  chk("t5_empty_claim", d, 64'd0);
    rd(16'h00, d);  chk("t5_pend_empty", d, 64'd0);
    chk("t5_best_zero", 64'(best_id), 64'd0);

    // 6: reset during service
    do_reset();
    wr(16'h08, 64'h04); wr(16'h50, 64'd3);
    irq_src[1] = 1'b1;
    idle(2 + SL);
    rd(16'h20, d);  chk("t6_claim", d, 64'd2);
    #2;
    reset = 1'b1;
    #1;
    chk("t6_rst_ext", 64'(ext_irq), 64'd0);
    chk("t6_rst_best", 64'(best_id), 64'd0);
    chk("t6_rst_rdata", bus.bus_read_data, 64'd0);
    idle(2);
    reset = 1'b0;
    idle(2 + SL);
    rd(16'h00, d);  chk("t6_repend", d, 64'h04);
    chk("t6_ext_off", 64'(ext_irq), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
